// File: rtl/fp_op_issue_if.sv
// fp_op_issue_if: issue-stage bus between the upstream producer and the
// fp_op_issue block.
//   Upstream side : in_valid, in_ready, a_in, b_in, o
//   Downstream    : out_valid, out_ready, a_out, b_out, o_out,
//                   special, special_result
//   Status        : div_by_zero (sticky), count (occupancy)
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both 1. The sender holds its payload stable while valid & ~ready. The
// receiver may drive ready independently of valid.
// slave modport = the issue block; master modport = its environment.
interface fp_op_issue_if #(
  parameter int M     = 8,
  parameter int N     = 23,
  parameter int DEPTH = 4
);
  localparam int W  = M + N + 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a_in;
  logic [W-1:0]  b_in;
  logic [1:0]    o;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  a_out;
  logic [W-1:0]  b_out;
  logic [1:0]    o_out;
  logic          special;
  logic [W-1:0]  special_result;
  logic          div_by_zero;
  logic [CW-1:0] count;

  modport slave (
    input  in_valid, a_in, b_in, o, out_ready,
    output in_ready, out_valid, a_out, b_out, o_out,
           special, special_result, div_by_zero, count
  );

  modport master (
    output in_valid, a_in, b_in, o, out_ready,
    input  in_ready, out_valid, a_out, b_out, o_out,
           special, special_result, div_by_zero, count
  );
endinterface

// File: rtl/fp_op_issue.sv
// fp_op_issue: upstream issue stage of the floating-point ALU.
// Buffers {A, B, op} in a DEPTH-entry FIFO. Each op is classified as it is
// pushed, and the FIFO stores whether the result is already resolved here
// (special) together with that result. The downstream datapaths then only
// ever see operands they can compute.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, discards the FIFO
//   bus  - fp_op_issue_if.slave (push side, pop side, div_by_zero, count)
module fp_op_issue #(
  parameter int M     = 8,
  parameter int N     = 23,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  fp_op_issue_if.slave  bus
);
  localparam int W  = M + N + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  localparam logic [W-1:0] QNAN_C = {1'b0, {M{1'b1}}, 1'b1, {(N-1){1'b0}}};

  // Operand classification; denormals fold into zero.
  logic a_exp_ones, a_exp_zero, a_mant_zero;
  logic b_exp_ones, b_exp_zero, b_mant_zero;
  logic a_zero, a_inf, a_nan, b_zero, b_inf, b_nan;
  logic sgn;

  assign a_exp_ones  = &a_exp_field(bus.a_in);
  assign a_exp_zero  = ~|a_exp_field(bus.a_in);
  assign a_mant_zero = ~|bus.a_in[N-1:0];
  assign b_exp_ones  = &a_exp_field(bus.b_in);
  assign b_exp_zero  = ~|a_exp_field(bus.b_in);
  assign b_mant_zero = ~|bus.b_in[N-1:0];

  assign a_zero = a_exp_zero;
  assign a_inf  = a_exp_ones & a_mant_zero;
  assign a_nan  = a_exp_ones & ~a_mant_zero;
  assign b_zero = b_exp_zero;
  assign b_inf  = b_exp_ones & b_mant_zero;
  assign b_nan  = b_exp_ones & ~b_mant_zero;
  assign sgn    = bus.a_in[W-1] ^ bus.b_in[W-1];

  function automatic logic [M-1:0] a_exp_field(input logic [W-1:0] x);
    return x[W-2:N];
  endfunction

  // Resolution of the incoming op.
  logic         spec_c;
  logic [W-1:0] res_c;
  logic         dbz_c;

  always_comb begin
    spec_c = 1'b0;
    res_c  = '0;
    dbz_c  = 1'b0;
    case (bus.o)
      2'b11: begin
        if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
          spec_c = 1'b1;
          res_c  = QNAN_C;
        end else if (a_inf) begin
          spec_c = 1'b1;
          res_c  = {sgn, {M{1'b1}}, {N{1'b0}}};
        end else if (b_zero) begin
          // A is finite and nonzero here, so this is a genuine divide by zero.
          spec_c = 1'b1;
          res_c  = {sgn, {M{1'b1}}, {N{1'b0}}};
          dbz_c  = 1'b1;
        end else if (b_inf | a_zero) begin
          spec_c = 1'b1;
          res_c  = {sgn, {(W-1){1'b0}}};
        end
      end
      2'b10: begin
        if (a_nan | b_nan | (a_zero & b_inf) | (a_inf & b_zero)) begin
          spec_c = 1'b1;
          res_c  = QNAN_C;
        end
      end
      default: begin
        if (a_nan | b_nan) begin
          spec_c = 1'b1;
          res_c  = QNAN_C;
        end
      end
    endcase
  end

  // FIFO storage and control.
  logic [W-1:0]  a_mem [DEPTH];
  logic [W-1:0]  b_mem [DEPTH];
  logic [1:0]    o_mem [DEPTH];
  logic          s_mem [DEPTH];
  logic [W-1:0]  r_mem [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          dbz_q;
  logic          ready_c, valid_c, push, pop;

  assign ready_c = (count_q < FULL_C) & ~rst;
  assign valid_c = (count_q != '0);
  assign push    = bus.in_valid & ready_c;
  assign pop     = valid_c & bus.out_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      a_mem[wr_ptr] <= bus.a_in;
      b_mem[wr_ptr] <= bus.b_in;
      o_mem[wr_ptr] <= bus.o;
      s_mem[wr_ptr] <= spec_c;
      r_mem[wr_ptr] <= res_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dbz_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (dbz_c) dbz_q <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Head fields read zero while empty so stale entries never leak out.
  assign bus.in_ready       = ready_c;
  assign bus.out_valid      = valid_c;
  assign bus.a_out          = valid_c ? a_mem[rd_ptr] : '0;
  assign bus.b_out          = valid_c ? b_mem[rd_ptr] : '0;
  assign bus.o_out          = valid_c ? o_mem[rd_ptr] : 2'b00;
  assign bus.special        = valid_c ? s_mem[rd_ptr] : 1'b0;
  assign bus.special_result = valid_c ? r_mem[rd_ptr] : '0;
  assign bus.div_by_zero    = dbz_q;
  assign bus.count          = count_q;
endmodule

// File: tb/tb_fp_op_issue.sv
// tb_fp_op_issue: directed bench for fp_op_issue (M=8, N=23, DEPTH=4).
// A queue model with IEEE-754 operand classes tracks expected FIFO contents
// and is compared against the DUT every negative clock edge; directed cases
// add hand-computed literal expectations.
module tb_fp_op_issue;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  o;
    logic        sp;
    logic [31:0] r;
  } ent_t;

  localparam int EW = $bits(ent_t);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [EW-1:0] exp_q[$];
  logic          m_dbz = 1'b0;

  fp_op_issue_if #(.M(8), .N(23), .DEPTH(DEPTH)) bus ();

  fp_op_issue #(.M(8), .N(23), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  localparam int C_NORM = 0, C_ZERO = 1, C_INF = 2, C_NAN = 3;

  function automatic int fp_class(input logic [31:0] x);
    int e;
    e = int'(x[30:23]);
    if (e == 0) return C_ZERO;
    if (e == 255) return (x[22:0] == 23'd0) ? C_INF : C_NAN;
    return C_NORM;
  endfunction

  // Returns {special, result}; dbz reports a true divide by zero.
  function automatic logic [32:0] resolve(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] op, output logic dbz);
    int ca, cb;
    logic [31:0] inf_s, zero_s;
    ca = fp_class(a);
    cb = fp_class(b);
    inf_s  = (a[31] ^ b[31]) ? 32'hFF80_0000 : 32'h7F80_0000;
    zero_s = (a[31] ^ b[31]) ? 32'h8000_0000 : 32'h0000_0000;
    dbz = 1'b0;
    if (ca == C_NAN || cb == C_NAN) return {1'b1, 32'h7FC0_0000};
    if (op == 2'b11) begin
      if ((ca == C_ZERO && cb == C_ZERO) || (ca == C_INF && cb == C_INF))
        return {1'b1, 32'h7FC0_0000};
      if (ca == C_INF) return {1'b1, inf_s};
      if (cb == C_ZERO) begin
        dbz = 1'b1;
        return {1'b1, inf_s};
      end
      if (cb == C_INF || ca == C_ZERO) return {1'b1, zero_s};
    end else if (op == 2'b10) begin
      if ((ca == C_ZERO && cb == C_INF) || (ca == C_INF && cb == C_ZERO))
        return {1'b1, 32'h7FC0_0000};
    end
    return 33'd0;
  endfunction

  logic        mdl_push, mdl_pop, mdl_dbz;
  logic [32:0] mdl_res;
  ent_t        mdl_e;

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_dbz = 1'b0;
    end else begin
      mdl_pop  = bus.out_ready && (exp_q.size() != 0);
      mdl_push = bus.in_valid && (exp_q.size() < DEPTH);
      if (mdl_pop) void'(exp_q.pop_front());
      if (mdl_push) begin
        mdl_res  = resolve(bus.a_in, bus.b_in, bus.o, mdl_dbz);
        mdl_e.a  = bus.a_in;
        mdl_e.b  = bus.b_in;
        mdl_e.o  = bus.o;
        mdl_e.sp = mdl_res[32];
        mdl_e.r  = mdl_res[31:0];
        exp_q.push_back(mdl_e);
        if (mdl_dbz) m_dbz = 1'b1;
      end
    end
  end

  ent_t cmp_e;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("out_valid", bus.out_valid, exp_q.size() != 0);
      chk("count", bus.count, exp_q.size());
      chk("in_ready", bus.in_ready, (exp_q.size() < DEPTH) && !rst);
      chk("div_by_zero", bus.div_by_zero, m_dbz);
      if (exp_q.size() != 0) cmp_e = exp_q[0];
      else cmp_e = '0;
      chk("a_out", bus.a_out, cmp_e.a);
      chk("b_out", bus.b_out, cmp_e.b);
      chk("o_out", bus.o_out, cmp_e.o);
      chk("special", bus.special, cmp_e.sp);
      chk("special_result", bus.special_result, cmp_e.r);
    end
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end at posedge+#1.
  task automatic push_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.o        = op;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 50) begin
      errors++;
      $display("FAIL push_timeout: in_ready stayed 0 expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.out_ready = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  // Push one op with out_ready low, check its resolution literally, pop it.
  task automatic one_case(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic exp_sp,
                          input logic [31:0] exp_r, input logic exp_dbz);
    bus.out_ready = 1'b0;
    push_op(a, b, op);
    @(negedge clk);
    chk({name, "_special"}, bus.special, exp_sp);
    chk({name, "_result"}, bus.special_result, exp_r);
    chk({name, "_dbz"}, bus.div_by_zero, exp_dbz);
    @(posedge clk);
    #1;
    drain(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.o         = 2'b00;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_dbz", bus.div_by_zero, 0);
    @(posedge clk);
    #1;

    // Normal divide, single op with out_ready high
    bus.out_ready = 1'b1;
    push_op(32'h4000_0000, 32'h3F80_0000, 2'b11);
    @(negedge clk);
    chk("norm_out_valid", bus.out_valid, 1);
    chk("norm_a_out", bus.a_out, 32'h4000_0000);
    chk("norm_special", bus.special, 0);
    @(negedge clk);
    chk("norm_count_back", bus.count, 0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Priority chain and other special cases before any divide by zero
    one_case("zero_div_zero", 32'h0000_0000, 32'h0000_0000, 2'b11, 1, 32'h7FC0_0000, 0);
    one_case("inf_div_inf",   32'h7F80_0000, 32'h7F80_0000, 2'b11, 1, 32'h7FC0_0000, 0);
    one_case("one_div_inf",   32'h3F80_0000, 32'h7F80_0000, 2'b11, 1, 32'h0000_0000, 0);
    one_case("nzero_div_two", 32'h8000_0000, 32'h4000_0000, 2'b11, 1, 32'h8000_0000, 0);
    one_case("ninf_div_two",  32'hFF80_0000, 32'h4000_0000, 2'b11, 1, 32'hFF80_0000, 0);
    one_case("nan_div_zero",  32'h7F80_0001, 32'h0000_0000, 2'b11, 1, 32'h7FC0_0000, 0);
    one_case("denorm_div_0",  32'h0000_0001, 32'h0000_0000, 2'b11, 1, 32'h7FC0_0000, 0);
    one_case("mul_zero_inf",  32'h0000_0000, 32'hFF80_0000, 2'b10, 1, 32'h7FC0_0000, 0);
    one_case("mul_inf_two",   32'h7F80_0000, 32'h4000_0000, 2'b10, 0, 32'h0000_0000, 0);
    one_case("add_nan",       32'h3F80_0000, 32'hFFC0_0000, 2'b00, 1, 32'h7FC0_0000, 0);
    one_case("sub_inf_inf",   32'h7F80_0000, 32'h7F80_0000, 2'b01, 0, 32'h0000_0000, 0);

    // Divide by zero: sticky flag
    one_case("neg_div_zero",  32'hBF80_0000, 32'h0000_0000, 2'b11, 1, 32'hFF80_0000, 1);
    one_case("dbz_sticky",    32'h4000_0000, 32'h3F80_0000, 2'b11, 0, 32'h0000_0000, 1);

    // Fill and backpressure
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push_op(32'h4000_0000 + 32'(i), 32'h3F80_0000, 2'(i));
    @(negedge clk);
    chk("full_count", bus.count, 4);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_head_a", bus.a_out, 32'h4000_0000);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a_in     = 32'h4000_0004;
    bus.b_in     = 32'h3F80_0000;
    bus.o        = 2'b00;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push_op(32'h4000_0004, 32'h3F80_0000, 2'b00);
    repeat (6) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("drained_count", bus.count, 0);
    @(posedge clk);
    #1;

    // Simultaneous push/pop at count=2 across pointer wrap
    push_op(32'h4100_0000, 32'h4000_0000, 2'b10);
    push_op(32'h4100_0001, 32'h4000_0000, 2'b10);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = 32'h4200_0000 + 32'(i);
      bus.b_in     = 32'h3F00_0000;
      bus.o        = 2'(i);
      @(negedge clk);
      chk("steady_count", bus.count, 2);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;

    // Reset mid-stream at count=3; in_valid during rst is ignored
    for (int i = 0; i < 3; i++)
      push_op(32'h4040_0000 + 32'(i), 32'h3F80_0000, 2'b00);
    @(negedge clk);
    chk("pre_rst_count", bus.count, 3);
    chk("pre_rst_dbz", bus.div_by_zero, 1);
    @(posedge clk);
    #1;
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.a_in     = 32'h3F80_0000;
    bus.b_in     = 32'h0000_0000;
    bus.o        = 2'b11;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_count", bus.count, 0);
    chk("post_rst_out_valid", bus.out_valid, 0);
    chk("post_rst_dbz", bus.div_by_zero, 0);
    chk("post_rst_in_ready", bus.in_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
